// File: rtl/ram_io_map_if.sv
// Address/data bus between the CPU and the data-RAM/IO block.
// The master drives the access; the slave returns registered read data and error flags.
interface ram_io_map_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic              WEN;
  logic              REN;
  logic [DATA_W-1:0] RDATA;
  logic              RVALID;
  logic              ERR;

  modport master (output ADDR, WDATA, WEN, REN, input RDATA, RVALID, ERR);
  modport slave  (input ADDR, WDATA, WEN, REN, output RDATA, RVALID, ERR);
endinterface

// File: rtl/ram_io_map.sv
// Data RAM plus a memory-mapped I/O window: output registers, captured input ports
// with pending/overflow flags, and a status register, all behind one-cycle reads.
module ram_io_map #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 64,
  parameter int IO_BASE = 64,
  parameter int N_OUT   = 2,
  parameter int N_IN    = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  ram_io_map_if.slave             bus,
  input  logic [N_IN*DATA_W-1:0]  IN_DATA,
  input  logic [N_IN-1:0]         IN_STB,
  output logic [N_OUT*DATA_W-1:0] OUT_DATA,
  output logic [N_OUT-1:0]        OUT_STB
);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [N_OUT*DATA_W-1:0] out_data_q, out_data_d;
  logic [N_OUT-1:0]        out_stb_q, out_stb_d;
  logic [N_IN*DATA_W-1:0]  cap_q, cap_d;
  logic [N_IN-1:0]         pend_q, pend_d;
  logic [N_IN-1:0]         ovf_q, ovf_d;

  logic [ADDR_W-1:0] io_off;
  logic              in_io;
  logic              hit_ram;
  logic [N_OUT-1:0]  hit_out;
  logic [N_IN-1:0]   hit_in;
  logic              hit_status;
  logic              mapped;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] rd_word;
  logic              rd_in;

  // Address decode: the I/O window is located by offset from IO_BASE.
  always_comb begin
    io_off     = bus.ADDR - IO_BASE_A;
    in_io      = (bus.ADDR >= IO_BASE_A);
    hit_ram    = (bus.ADDR < DEPTH_A);
    ram_idx    = bus.ADDR[RAM_AW-1:0];
    hit_out    = '0;
    hit_in     = '0;
    for (int k = 0; k < N_OUT; k++)
      hit_out[k] = in_io && (io_off == ADDR_W'(k));
    for (int k = 0; k < N_IN; k++)
      hit_in[k] = in_io && (io_off == ADDR_W'(N_OUT + k));
    hit_status = in_io && (io_off == ADDR_W'(N_OUT + N_IN));
    mapped     = hit_ram || (|hit_out) || (|hit_in) || hit_status;
  end

  always_comb begin
    status_word                 = '0;
    status_word[0 +: N_IN]      = pend_q;
    status_word[N_IN +: N_IN]   = ovf_q;

    // A simultaneous write to the same RAM/OUT location is forwarded to the read.
    rd_word = '0;
    if (hit_ram)
      rd_word = bus.WEN ? bus.WDATA : mem[ram_idx];
    for (int k = 0; k < N_OUT; k++)
      if (hit_out[k])
        rd_word = bus.WEN ? bus.WDATA : out_data_q[k*DATA_W +: DATA_W];
    for (int k = 0; k < N_IN; k++)
      if (hit_in[k])
        rd_word = cap_q[k*DATA_W +: DATA_W];
    if (hit_status)
      rd_word = status_word;

    rvalid_d = bus.REN;
    rdata_d  = bus.REN ? rd_word : rdata_q;
    err_d    = (bus.WEN || bus.REN) && (!mapped || (bus.WEN && (|hit_in)));

    out_data_d = out_data_q;
    out_stb_d  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (bus.WEN && hit_out[k]) begin
        out_data_d[k*DATA_W +: DATA_W] = bus.WDATA;
        out_stb_d[k]                   = 1'b1;
      end
    end

    // A read that coincides with a strobe consumes the old capture, so no overflow.
    cap_d  = cap_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    rd_in  = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      rd_in = bus.REN && hit_in[k];
      if (IN_STB[k])
        cap_d[k*DATA_W +: DATA_W] = IN_DATA[k*DATA_W +: DATA_W];
      pend_d[k] = IN_STB[k] || (pend_q[k] && !rd_in);
      if (bus.WEN && hit_status && bus.WDATA[N_IN + k])
        ovf_d[k] = 1'b0;
      if (IN_STB[k] && pend_q[k] && !rd_in)
        ovf_d[k] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && bus.WEN && hit_ram)
      mem[ram_idx] <= bus.WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      out_data_q <= '0;
      out_stb_q  <= '0;
      cap_q      <= '0;
      pend_q     <= '0;
      ovf_q      <= '0;
    end else begin
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      out_data_q <= out_data_d;
      out_stb_q  <= out_stb_d;
      cap_q      <= cap_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.RDATA  = rdata_q;
  assign bus.RVALID = rvalid_q;
  assign bus.ERR    = err_q;
  assign OUT_DATA   = out_data_q;
  assign OUT_STB    = out_stb_q;
endmodule

// File: tb/tb_ram_io_map.sv
// Scoreboard bench for ram_io_map: stimulus pushes expected responses, a negedge
// monitor pops them whenever the DUT presents read data, errors or output strobes.
module tb_ram_io_map;
  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_stb;
  logic [31:0] out_data;
  logic [1:0]  out_stb;

  int errors = 0;
  int checks = 0;

  logic [16:0] rd_q[$];
  logic [33:0] out_q[$];
  int          err_q[$];

  ram_io_map_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  ram_io_map dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus),
    .IN_DATA(in_data),
    .IN_STB(in_stb),
    .OUT_DATA(out_data),
    .OUT_STB(out_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic ren, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] stb, input logic [31:0] idata);
    @(negedge clk);
    bus.WEN   = wen;
    bus.REN   = ren;
    bus.ADDR  = addr;
    bus.WDATA = wdata;
    in_stb    = stb;
    in_data   = idata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'd0, 16'd0, 2'b00, 32'd0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    drive(1'b1, 1'b0, addr, data, 2'b00, 32'd0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input logic exp_err);
    drive(1'b0, 1'b1, addr, 16'd0, 2'b00, 32'd0);
    rd_q.push_back({exp_err, exp});
  endtask

  // Outputs change only after posedge, so negedge sampling is race-free.
  always @(negedge clk) begin
    logic [16:0] e;
    logic [33:0] o;
    if (bus.RVALID) begin
      if (rd_q.size() == 0) begin
        check("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = rd_q.pop_front();
        check("rdata", 64'(bus.RDATA), 64'(e[15:0]));
        check("rd_err", 64'(bus.ERR), 64'(e[16]));
      end
    end else if (bus.ERR) begin
      if (err_q.size() == 0) check("unexpected_err", 64'd1, 64'd0);
      else void'(err_q.pop_front());
    end
    if (out_stb != 2'b00) begin
      if (out_q.size() == 0) begin
        check("unexpected_out_stb", 64'(out_stb), 64'd0);
      end else begin
        o = out_q.pop_front();
        check("out_stb", 64'(out_stb), 64'(o[33:32]));
        check("out_data", 64'(out_data), 64'(o[31:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.WEN = 1'b0; bus.REN = 1'b0; bus.ADDR = '0; bus.WDATA = '0;
    in_stb = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check("reset_rdata", 64'(bus.RDATA), 64'd0);
    check("reset_rvalid", 64'(bus.RVALID), 64'd0);
    check("reset_err", 64'(bus.ERR), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_stb", 64'(out_stb), 64'd0);
    rst = 1'b0;

    // RAM write then read-back, hold while idle, then reset overriding a read
    wr(16'd5, 16'h1234);
    rd(16'd5, 16'h1234, 1'b0);
    idle();
    @(negedge clk);
    check("rdata_hold", 64'(bus.RDATA), 64'h1234);
    check("rvalid_pulse", 64'(bus.RVALID), 64'd0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 16'd5, 16'd0, 2'b00, 32'd0);
    @(negedge clk);
    check("rst_read_rdata", 64'(bus.RDATA), 64'd0);
    check("rst_read_rvalid", 64'(bus.RVALID), 64'd0);
    rst = 1'b0;
    bus.REN = 1'b0;

    // Same-cycle write/read bypass on the last RAM word
    drive(1'b1, 1'b1, 16'd63, 16'hBEEF, 2'b00, 32'd0);
    rd_q.push_back({1'b0, 16'hBEEF});
    idle();
    rd(16'd63, 16'hBEEF, 1'b0);

    // Output registers
    wr(16'd64, 16'h00AA);
    out_q.push_back({2'b01, 32'h0000_00AA});
    rd(16'd64, 16'h00AA, 1'b0);
    drive(1'b1, 1'b1, 16'd65, 16'h5555, 2'b00, 32'd0);
    rd_q.push_back({1'b0, 16'h5555});
    out_q.push_back({2'b10, 32'h5555_00AA});

    // Input capture, pending and overflow
    drive(1'b0, 1'b0, 16'd0, 16'd0, 2'b10, 32'h0042_0000);
    rd(16'd68, 16'h0002, 1'b0);
    rd(16'd67, 16'h0042, 1'b0);
    rd(16'd68, 16'h0000, 1'b0);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 32'h0000_0011);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 32'h0000_0022);
    rd(16'd68, 16'h0005, 1'b0);
    drive(1'b1, 1'b1, 16'd68, 16'h0004, 2'b00, 32'd0);
    rd_q.push_back({1'b0, 16'h0005});
    rd(16'd68, 16'h0001, 1'b0);

    // Read/strobe collision on IN[0]
    rd(16'd66, 16'h0022, 1'b0);
    drive(1'b0, 1'b0, 16'd0, 16'd0, 2'b01, 32'h0000_0011);
    drive(1'b0, 1'b1, 16'd66, 16'd0, 2'b01, 32'h0000_0077);
    rd_q.push_back({1'b0, 16'h0011});
    rd(16'd68, 16'h0001, 1'b0);
    rd(16'd66, 16'h0077, 1'b0);
    rd(16'd68, 16'h0000, 1'b0);

    // Unmapped and illegal accesses
    rd(16'd70, 16'h0000, 1'b1);
    wr(16'd66, 16'h1111);
    err_q.push_back(1);
    rd(16'd66, 16'h0077, 1'b0);
    rd(16'd69, 16'h0000, 1'b1);
    wr(16'd70, 16'hFFFF);
    err_q.push_back(1);
    rd(16'd65, 16'h5555, 1'b0);
    idle();
    repeat (3) @(negedge clk);

    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    check("err_queue_drained", 64'(err_q.size()), 64'd0);
    check("out_queue_drained", 64'(out_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
